// File: rtl/ahbl_memreq_bridge_if.sv
// ahbl_memreq_bridge_if
//   Bundles the AHB-Lite subordinate bus and the cache-controller user request
//   port used by ahbl_memreq_bridge.
//   slave  : bridge view (AHB inputs in, responses out; requests out, i_* in)
//   master : environment view (bus master + cache controller), directions mirrored
//   AHB:   ahbls_hready, ahbls_hsel, ahbls_htrans[1:0], ahbls_hwrite, ahbls_hsize[2:0],
//          ahbls_haddr[31:0], ahbls_hwdata[31:0] -> bridge
//          ahbls_hready_resp, ahbls_hresp, ahbls_hrdata[31:0] <- bridge
//   Cache: o_rd_en, o_wr_en, o_addr[31:0], o_data[31:0], o_mask[3:0] <- bridge
//          i_data[31:0], i_busy -> bridge
interface ahbl_memreq_bridge_if;
  logic        ahbls_hready;
  logic        ahbls_hsel;
  logic [1:0]  ahbls_htrans;
  logic        ahbls_hwrite;
  logic [2:0]  ahbls_hsize;
  logic [31:0] ahbls_haddr;
  logic [31:0] ahbls_hwdata;
  logic        ahbls_hready_resp;
  logic        ahbls_hresp;
  logic [31:0] ahbls_hrdata;
  logic        o_rd_en;
  logic        o_wr_en;
  logic [31:0] o_addr;
  logic [31:0] o_data;
  logic [3:0]  o_mask;
  logic [31:0] i_data;
  logic        i_busy;

  modport slave (
    input  ahbls_hready, ahbls_hsel, ahbls_htrans, ahbls_hwrite, ahbls_hsize,
           ahbls_haddr, ahbls_hwdata, i_data, i_busy,
    output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
           o_rd_en, o_wr_en, o_addr, o_data, o_mask
  );

  modport master (
    output ahbls_hready, ahbls_hsel, ahbls_htrans, ahbls_hwrite, ahbls_hsize,
           ahbls_haddr, ahbls_hwdata, i_data, i_busy,
    input  ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
           o_rd_en, o_wr_en, o_addr, o_data, o_mask
  );
endinterface

// File: rtl/ahbl_memreq_bridge.sv
// ahbl_memreq_bridge
//   AHB-Lite subordinate in front of the write-through cache controller. Each
//   accepted NONSEQ/SEQ transfer becomes one single-cycle rd/wr request pulse;
//   the data phase is stretched until the controller drops busy. Illegal
//   size/alignment gets a two-cycle ERROR without touching the controller, and
//   a watchdog turns an endless busy into an ERROR.
// Ports
//   clk  : system clock (shared with the cache controller)
//   rst  : synchronous reset, active-high
//   bus  : ahbl_memreq_bridge_if.slave (AHB-Lite subordinate + cache request port)
// Parameters
//   TIMEOUT_CYCLES : busy WAIT cycles tolerated before ERROR; 0 disables
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | no data phase pending; zero-wait OKAY, accepts address phases
// ISSUE  | first data-phase cycle; fires the request once controller is free
// WAIT   | waiting for busy low; completion cycle also accepts next address
// ERR1   | first ERROR cycle (hready low)
// ERR2   | second ERROR cycle (hready high); accepts address phases
module ahbl_memreq_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  ahbl_memreq_bridge_if.slave  bus
);

  localparam int unsigned WDW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ERR1  = 3'd3,
    S_ERR2  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      mask_q, mask_d;
  logic [31:0]     data_q, data_d;
  logic            write_q, write_d;
  logic [WDW-1:0]  wdog_q, wdog_d;

  logic            accept;
  logic            req_legal;
  logic [3:0]      req_mask;
  logic            open_addr;
  logic            rd_c, wr_c;
  logic            hready_c, hresp_c;
  logic [31:0]     hrdata_c;
  logic            unused_htrans0;

  assign unused_htrans0 = bus.ahbls_htrans[0];

  assign accept = bus.ahbls_hready & bus.ahbls_hsel & bus.ahbls_htrans[1];

  // Size/alignment legality and lane mask of the address phase on the bus.
  always_comb begin
    req_legal = 1'b0;
    req_mask  = 4'b0000;
    case (bus.ahbls_hsize)
      3'd0: begin
        req_legal = 1'b1;
        req_mask  = 4'b0001 << bus.ahbls_haddr[1:0];
      end
      3'd1: begin
        req_legal = ~bus.ahbls_haddr[0];
        req_mask  = bus.ahbls_haddr[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        req_legal = (bus.ahbls_haddr[1:0] == 2'b00);
        req_mask  = 4'b1111;
      end
      default: begin
        req_legal = 1'b0;
        req_mask  = 4'b0000;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    data_d    = data_q;
    write_d   = write_q;
    wdog_d    = wdog_q;
    open_addr = 1'b0;
    rd_c      = 1'b0;
    wr_c      = 1'b0;
    hready_c  = 1'b1;
    hresp_c   = 1'b0;
    hrdata_c  = 32'h0;

    case (state_q)
      S_IDLE: open_addr = 1'b1;
      S_ISSUE: begin
        hready_c = 1'b0;
        wdog_d   = '0;
        // Never hand a request to a controller that is still busy.
        if (!bus.i_busy) begin
          rd_c    = ~write_q;
          wr_c    = write_q;
          data_d  = bus.ahbls_hwdata;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.i_busy) begin
          hready_c = 1'b0;
          if (TIMEOUT_CYCLES != 0) begin
            if (wdog_q == WD_LAST) begin
              state_d = S_ERR1;
            end else begin
              wdog_d = wdog_q + WDW'(1);
            end
          end
        end else begin
          hrdata_c  = write_q ? 32'h0 : bus.i_data;
          open_addr = 1'b1;
        end
      end
      S_ERR1: begin
        hready_c = 1'b0;
        hresp_c  = 1'b1;
        state_d  = S_ERR2;
      end
      S_ERR2: begin
        hresp_c   = 1'b1;
        open_addr = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Shared address-phase handling lets a completing data phase chain
    // straight into the next transfer without an IDLE bubble.
    if (open_addr) begin
      if (accept) begin
        if (req_legal) begin
          state_d = S_ISSUE;
          addr_d  = {bus.ahbls_haddr[31:2], 2'b00};
          mask_d  = req_mask;
          write_d = bus.ahbls_hwrite;
        end else begin
          state_d = S_ERR1;
        end
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      mask_q  <= 4'h0;
      data_q  <= 32'h0;
      write_q <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      write_q <= write_d;
      wdog_q  <= wdog_d;
    end
  end

  // hwdata is only valid during the data phase, so ISSUE forwards it live and
  // the captured copy holds it afterwards.
  assign bus.o_data            = (state_q == S_ISSUE) ? bus.ahbls_hwdata : data_q;
  assign bus.o_addr            = addr_q;
  assign bus.o_mask            = mask_q;
  assign bus.o_rd_en           = rd_c & ~rst;
  assign bus.o_wr_en           = wr_c & ~rst;
  assign bus.ahbls_hready_resp = hready_c;
  assign bus.ahbls_hresp       = hresp_c;
  assign bus.ahbls_hrdata      = hrdata_c;

endmodule
